// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared datapath widths and data memory controller state type
package data_ram_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    typedef enum logic {CLEAR, IDLE} ram_state_t;
endpackage

// File: rtl/data_ram_ctl_ram_core.sv
// ram_core: storage array with one synchronous write port and a combinational read
module ram_core #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int DEPTH = 2**AW
)(
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_ram_ctl.sv
// data_ram_ctl: data memory with registered write-first read, range checks and post-reset clear
module data_ram_ctl
    import data_ram_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int DEPTH = 2**AW,
    parameter int CLEAR_ON_RESET = 1
)(
    input  logic          CLK,
    input  logic          reset,
    input  logic          RdEn,
    input  logic [AW-1:0] RdAddr,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    output logic [DW-1:0] RdData,
    output logic          RdValid,
    output logic          Busy,
    output logic          OobErr
);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    ram_state_t state;
    logic [AW:0] cnt;
    logic [DW-1:0] core_rd, wd;
    logic [AW-1:0] wa;
    logic rd_oob, wr_oob, wr_ok, bypass, we;
    assign Busy = state == CLEAR;
    assign rd_oob = {1'b0, RdAddr} >= LIM;
    assign wr_oob = {1'b0, WrAddr} >= LIM;
    assign wr_ok = WrEn && !wr_oob;
    assign bypass = wr_ok && WrAddr == RdAddr;
    // the clear sweep owns the single write port while Busy
    assign we = !reset && (Busy || wr_ok);
    assign wa = Busy ? cnt[AW-1:0] : WrAddr;
    assign wd = Busy ? '0 : WrData;
    ram_core #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_core (
        .CLK(CLK), .we(we), .waddr(wa), .wdata(wd), .raddr(RdAddr), .rdata(core_rd)
    );
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
            cnt <= '0;
            RdData <= '0;
            RdValid <= 1'b0;
            OobErr <= 1'b0;
        end else if (Busy) begin
            cnt <= cnt + 1'b1;
            state <= cnt == LAST ? IDLE : CLEAR;
            RdValid <= 1'b0;
        end else begin
            RdValid <= RdEn;
            if (RdEn) RdData <= rd_oob ? '0 : bypass ? WrData : core_rd;
            OobErr <= OobErr | (RdEn & rd_oob) | (WrEn & wr_oob);
        end
    end
endmodule

// File: tb/tb_data_ram_ctl.sv
// tb_data_ram_ctl: scoreboard bench running a full-depth and a 200-word instance side by side
module tb_data_ram_ctl;
    logic CLK = 0;
    always #5 CLK = ~CLK;
    logic reset = 1, RdEn = 0, WrEn = 0;
    logic [7:0] RdAddr = 0, WrAddr = 0, WrData = 0;
    logic [7:0] rd [2];
    logic rv [2], bz [2], oe [2];
    data_ram_ctl #(.DW(8), .AW(8), .DEPTH(256), .CLEAR_ON_RESET(1)) u0 (
        .CLK(CLK), .reset(reset), .RdEn(RdEn), .RdAddr(RdAddr), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .RdData(rd[0]), .RdValid(rv[0]), .Busy(bz[0]), .OobErr(oe[0])
    );
    data_ram_ctl #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1)) u1 (
        .CLK(CLK), .reset(reset), .RdEn(RdEn), .RdAddr(RdAddr), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .RdData(rd[1]), .RdValid(rv[1]), .Busy(bz[1]), .OobErr(oe[1])
    );
    logic [7:0] mem [2][256];
    int busy [2] = '{0, 0};
    int cidx [2] = '{0, 0};
    logic ev [2] = '{0, 0};
    logic eo [2] = '{0, 0};
    logic rs [2] = '{0, 0};
    logic [7:0] hold [2] = '{0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int errors = 0, checks = 0;
    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask
    // reference: a reset arms a DEPTH-cycle sweep, afterwards plain array semantics
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            logic [7:0] v;
            d = i ? 200 : 256;
            if (reset) begin
                busy[i] = d; cidx[i] = 0; ev[i] = 0; eo[i] = 0; rs[i] = 1;
            end else if (busy[i] > 0) begin
                mem[i][cidx[i]] = 0; cidx[i]++; busy[i]--; ev[i] = 0;
            end else begin
                ev[i] = RdEn;
                if (RdEn) begin
                    v = int'(RdAddr) >= d ? 8'h00 : (WrEn && WrAddr == RdAddr) ? WrData : mem[i][RdAddr];
                    if (i == 0) q0.push_back(v); else q1.push_back(v);
                end
                if (WrEn && int'(WrAddr) < d) mem[i][WrAddr] = WrData;
                if ((RdEn && int'(RdAddr) >= d) || (WrEn && int'(WrAddr) >= d)) eo[i] = 1;
            end
        end
    end
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin hold[i] = 0; rs[i] = 0; end
            chk("busy", i, 32'(bz[i]), 32'(busy[i] > 0));
            chk("oob_err", i, 32'(oe[i]), 32'(eo[i]));
            chk("rd_valid", i, 32'(rv[i]), 32'(ev[i]));
            if (ev[i]) begin
                if (i == 0 && q0.size() > 0) hold[i] = q0.pop_front();
                else if (i == 1 && q1.size() > 0) hold[i] = q1.pop_front();
            end
            chk("rd_data", i, 32'(rd[i]), 32'(hold[i]));
        end
    end
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask
    task automatic op(input logic re, input logic [7:0] ra, input logic we, input logic [7:0] wa, input logic [7:0] wd);
        RdEn = re; RdAddr = ra; WrEn = we; WrAddr = wa; WrData = wd;
        cyc();
    endtask
    task automatic count_busy(input int exp0, input int exp1);
        int c0, c1;
        c0 = 0; c1 = 0;
        for (int t = 0; t < 300 && (bz[0] || bz[1]); t++) begin
            c0 += int'(bz[0]); c1 += int'(bz[1]);
            cyc();
        end
        RdEn = 0; WrEn = 0;
        chk("busy_len", 0, c0, exp0);
        chk("busy_len", 1, c1, exp1);
    endtask
    initial begin
        cyc();
        reset = 0;
        RdEn = 1; RdAddr = 5; WrEn = 1; WrAddr = 5; WrData = 8'hFF;
        count_busy(256, 200);
        op(1, 0, 0, 0, 0); op(1, 16, 0, 0, 0); op(1, 255, 0, 0, 0); op(0, 0, 0, 0, 0);
        op(0, 0, 1, 16, 8'hA5); op(1, 16, 0, 0, 0); op(0, 0, 0, 0, 0); op(0, 0, 0, 0, 0);
        op(1, 244, 1, 244, 8'h3C); op(1, 5, 0, 0, 0); op(0, 0, 0, 0, 0);
        op(0, 0, 1, 210, 8'h77); op(1, 210, 0, 0, 0); op(0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++)
            op(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        op(0, 0, 1, 150, 8'h11); op(1, 150, 0, 0, 0);
        reset = 1; RdEn = 1; RdAddr = 150;
        cyc();
        reset = 0; RdEn = 0;
        cyc(99);
        reset = 1;
        cyc();
        reset = 0;
        count_busy(256, 200);
        op(1, 150, 0, 0, 0); op(0, 0, 0, 0, 0);
        for (int n = 0; n < 200; n++)
            op(1'($urandom), 8'($urandom_range(140, 220)), 1'($urandom), 8'($urandom_range(140, 220)), 8'($urandom));
        op(0, 0, 0, 0, 0); cyc(3);
        chk("drain", 0, q0.size(), 0);
        chk("drain", 1, q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
